// File: rtl/sig_cmn_upsizer_rv.sv
// Ready/valid width upsizer: packs RATIO narrow beats (lane 0 first) into one wide word,
// closing a word early on last_in; unfilled lanes read as data 0 / keep 0.
module sig_cmn_upsizer_rv #(
  parameter int DWIDTH = 32,
  parameter int RATIO  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [DWIDTH-1:0]        data_in,
  input  logic                     last_in,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [DWIDTH*RATIO-1:0]  data_out,
  output logic [RATIO-1:0]         keep_out,
  output logic                     last_out
);

  localparam int            CW      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int            OW      = DWIDTH * RATIO;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]    acc_data_q, acc_data_d;
  logic [RATIO-1:0] acc_keep_q, acc_keep_d;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic             out_vld_q, out_vld_d;

  logic [OW-1:0]    word_w;
  logic [RATIO-1:0] keep_w;
  logic             accept, complete;

  // The output register alone gates acceptance, so ready never sees valid_in/data_in.
  assign ready_out = !out_vld_q || ready_in;
  assign accept    = valid_in && ready_out;
  assign complete  = accept && ((cnt_q == CNT_MAX) || last_in);

  always_comb begin
    word_w     = acc_data_q;
    keep_w     = acc_keep_q;
    cnt_d      = cnt_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;
    out_vld_d  = out_vld_q;

    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) begin
        word_w[k*DWIDTH +: DWIDTH] = data_in;
        keep_w[k]                  = 1'b1;
      end
    end

    if (complete) begin
      // A consume in the same cycle is covered: the new word simply replaces the old one.
      out_data_d = word_w;
      out_keep_d = keep_w;
      out_last_d = last_in;
      out_vld_d  = 1'b1;
      cnt_d      = '0;
      acc_data_d = '0;
      acc_keep_d = '0;
    end else begin
      if (accept) begin
        acc_data_d = word_w;
        acc_keep_d = keep_w;
        cnt_d      = cnt_q + CW'(1);
      end
      if (out_vld_q && ready_in) begin
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign valid_out = out_vld_q;
  assign data_out  = out_data_q;
  assign keep_out  = out_keep_q;
  assign last_out  = out_last_q;

endmodule
